// File: rtl/eth_txbytefeed.sv
// eth_txbytefeed: buffers 32-bit TX frame words and feeds them bytewise to the MAC, returning per-frame status.
module eth_txbytefeed #(
  parameter int DEPTH     = 4,
  parameter int START_THR = 2
) (
  input  logic        MTxClk,
  input  logic        Reset_n,
  input  logic [31:0] WrData,
  input  logic        WrLast,
  input  logic [1:0]  WrBytes,
  input  logic        WrValid,
  output logic        WrReady,
  output logic        TxStartFrm,
  output logic        TxEndFrm,
  output logic        TxUnderRun,
  output logic [7:0]  TxData,
  input  logic        TxUsedData,
  input  logic        TxDone,
  input  logic        TxRetry,
  input  logic        TxAbort,
  output logic        StatValid,
  output logic        StatOk,
  output logic        StatRetry,
  output logic        StatAbort,
  output logic        StatUnderRun
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [2:0] {IDLE, START, DATA, WAITST, UNDER, FLUSH} state_t;
  logic [34:0]   mem [DEPTH];
  logic [34:0]   head, nxt;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, last_cnt_q, last_cnt_d;
  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    data_q, data_d;
  logic          start_q, start_d, end_q, end_d, under_q, under_d;
  logic          sv_q, sv_d, ok_q, ok_d, rt_q, rt_d, ab_q, ab_d, ur_q, ur_d;
  logic          fl_rt_q, fl_rt_d, fl_ab_q, fl_ab_d, fl_ur_q, fl_ur_d;
  logic          push, pop;

  function automatic logic [7:0] sel(input logic [31:0] w, input logic [1:0] i);
    return w[{i, 3'b000} +: 8];
  endfunction

  assign push = WrValid && WrReady;
  assign head = mem[rd_ptr_q];
  assign nxt  = mem[rd_ptr_q + AW'(1)];

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    data_d   = data_q;
    start_d  = start_q;
    end_d    = end_q;
    under_d  = under_q;
    fl_rt_d  = fl_rt_q;
    fl_ab_d  = fl_ab_q;
    fl_ur_d  = fl_ur_q;
    sv_d     = 1'b0;
    ok_d     = 1'b0;
    rt_d     = 1'b0;
    ab_d     = 1'b0;
    ur_d     = 1'b0;
    pop      = 1'b0;
    case (state_q)
      IDLE: if (count_q >= CW'(START_THR) || last_cnt_q != '0) begin
        state_d = START;
        start_d = 1'b1;
        idx_d   = 2'd0;
        data_d  = sel(head[31:0], 2'd0);
        end_d   = head[34] && head[33:32] == 2'd0;
        fl_rt_d = 1'b0;
        fl_ab_d = 1'b0;
        fl_ur_d = 1'b0;
      end
      START, DATA: if (TxAbort || TxRetry) begin
        state_d = FLUSH;
        start_d = 1'b0;
        end_d   = 1'b0;
        data_d  = 8'h00;
        fl_ab_d = TxAbort;
        fl_rt_d = !TxAbort;
      end else if (TxUsedData) begin
        start_d = 1'b0;
        if (end_q) begin
          pop     = 1'b1;
          end_d   = 1'b0;
          data_d  = 8'h00;
          state_d = WAITST;
        end else if (idx_q == 2'd3) begin
          pop = 1'b1;
          // the next word must already be buffered, otherwise the MAC runs dry
          if (count_q >= CW'(2)) begin
            idx_d   = 2'd0;
            data_d  = sel(nxt[31:0], 2'd0);
            end_d   = nxt[34] && nxt[33:32] == 2'd0;
            state_d = DATA;
          end else begin
            under_d = 1'b1;
            data_d  = 8'h00;
            fl_ur_d = 1'b1;
            state_d = UNDER;
          end
        end else begin
          idx_d   = idx_q + 2'd1;
          data_d  = sel(head[31:0], idx_q + 2'd1);
          end_d   = head[34] && head[33:32] == idx_q + 2'd1;
          state_d = DATA;
        end
      end
      UNDER: if (TxAbort || TxDone) begin
        under_d = 1'b0;
        fl_ab_d = TxAbort;
        state_d = FLUSH;
      end
      WAITST: if (TxAbort || TxRetry || TxDone) begin
        sv_d    = 1'b1;
        ab_d    = TxAbort;
        rt_d    = !TxAbort && TxRetry;
        ok_d    = !TxAbort && !TxRetry;
        state_d = IDLE;
      end
      FLUSH: if (count_q != '0) begin
        pop = 1'b1;
        if (head[34]) begin
          sv_d    = 1'b1;
          rt_d    = fl_rt_q;
          ab_d    = fl_ab_q;
          ur_d    = fl_ur_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    count_d    = count_q + CW'(push) - CW'(pop);
    last_cnt_d = last_cnt_q + CW'(push && WrLast) - CW'(pop && head[34]);
  end

  always_ff @(posedge MTxClk)
    if (push) mem[wr_ptr_q] <= {WrLast, WrBytes, WrData};

  always_ff @(posedge MTxClk or negedge Reset_n)
    if (!Reset_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_cnt_q <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      start_q    <= 1'b0;
      end_q      <= 1'b0;
      under_q    <= 1'b0;
      sv_q       <= 1'b0;
      ok_q       <= 1'b0;
      rt_q       <= 1'b0;
      ab_q       <= 1'b0;
      ur_q       <= 1'b0;
      fl_rt_q    <= 1'b0;
      fl_ab_q    <= 1'b0;
      fl_ur_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      last_cnt_q <= last_cnt_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      start_q    <= start_d;
      end_q      <= end_d;
      under_q    <= under_d;
      sv_q       <= sv_d;
      ok_q       <= ok_d;
      rt_q       <= rt_d;
      ab_q       <= ab_d;
      ur_q       <= ur_d;
      fl_rt_q    <= fl_rt_d;
      fl_ab_q    <= fl_ab_d;
      fl_ur_q    <= fl_ur_d;
    end

  assign WrReady      = count_q != CW'(DEPTH);
  assign TxStartFrm   = start_q;
  assign TxEndFrm     = end_q;
  assign TxUnderRun   = under_q;
  assign TxData       = data_q;
  assign StatValid    = sv_q;
  assign StatOk       = ok_q;
  assign StatRetry    = rt_q;
  assign StatAbort    = ab_q;
  assign StatUnderRun = ur_q;
endmodule
